// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// fill-level output, synchronous flush and sticky overflow/underflow flags.
// FWFT selects registered read (0) or first-word-fall-through read (1).
module sync_fifo_prog #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int FWFT     = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                winc_i,
    input  logic                rinc_i,
    input  logic                flush_i,
    input  logic [ADDRSIZE:0]   afull_thr_i,
    input  logic [ADDRSIZE:0]   aempty_thr_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic                rempty_o,
    output logic                wfull_o,
    output logic                w_almost_full_o,
    output logic                r_almost_empty_o,
    output logic [ADDRSIZE:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int unsigned DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] FULL_CNT = {1'b1, {ADDRSIZE{1'b0}}};

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [ADDRSIZE-1:0] wptr_q, wptr_d;
    logic [ADDRSIZE-1:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                wr_en, rd_en;

    // Status flags decode from the registered count; almost flags follow the live thresholds.
    assign rempty_o         = (count_q == '0);
    assign wfull_o          = (count_q == FULL_CNT);
    assign count_o          = count_q;
    assign w_almost_full_o  = (count_q >= afull_thr_i);
    assign r_almost_empty_o = (count_q <= aempty_thr_i);
    assign overflow_o       = ovf_q;
    assign underflow_o      = unf_q;

    // Accepted accesses; flush masks both in the same cycle.
    assign wr_en = winc_i & ~wfull_o & ~flush_i;
    assign rd_en = rinc_i & ~rempty_o & ~flush_i;

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (winc_i & wfull_o);
        unf_d   = unf_q | (rinc_i & rempty_o);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (rd_en) rptr_d = rptr_q + 1'b1;
            if (wr_en && !rd_en)      count_d = count_q + 1'b1;
            else if (rd_en && !wr_en) count_d = count_q - 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array write; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q] <= wdata_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; don't-care while empty.
            always_comb rdata_o = mem_q[rptr_q];
        end else begin : g_std
            logic [DATASIZE-1:0] rdata_q;
            // Registered read: capture head on an accepted read, hold otherwise.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)    rdata_q <= '0;
                else if (rd_en) rdata_q <= mem_q[rptr_q];
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog: one registered-read
// instance and one first-word-fall-through instance.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wdata = '0, wdata1 = '0;
    logic       winc = 1'b0, rinc = 1'b0, flush = 1'b0;
    logic       winc1 = 1'b0, rinc1 = 1'b0, flush1 = 1'b0;
    logic [4:0] afull_thr = 5'd14, aempty_thr = 5'd2;

    logic [7:0] rdata, rdata1;
    logic       rempty, wfull, afull, aempty, ovf, unf;
    logic       rempty1, wfull1, afull1, aempty1, ovf1, unf1;
    logic [4:0] count, count1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wdata_i(wdata), .winc_i(winc), .rinc_i(rinc),
        .flush_i(flush), .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .rdata_o(rdata), .rempty_o(rempty), .wfull_o(wfull),
        .w_almost_full_o(afull), .r_almost_empty_o(aempty), .count_o(count),
        .overflow_o(ovf), .underflow_o(unf)
    );

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .wdata_i(wdata1), .winc_i(winc1), .rinc_i(rinc1),
        .flush_i(flush1), .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
        .rdata_o(rdata1), .rempty_o(rempty1), .wfull_o(wfull1),
        .w_almost_full_o(afull1), .r_almost_empty_o(aempty1), .count_o(count1),
        .overflow_o(ovf1), .underflow_o(unf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0 || ovf !== 1'b0 ||
            unf !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset: count=%0d empty=%b full=%b ovf=%b unf=%b rdata=%h required 0 1 0 0 0 00",
                     count, rempty, wfull, ovf, unf, rdata);
        end
        checks++;
        if (count1 !== 5'd0 || rempty1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_fwft: count=%0d empty=%b required 0 1", count1, rempty1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int cnt;
        afull_thr = 5'd14;
        aempty_thr = 5'd2;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(i);
            winc = 1'b1;
            tick();
            cnt = (i + 1 > 16) ? 16 : i + 1;
            checks++;
            if (count !== 5'(cnt) || wfull !== (cnt == 16) || afull !== (cnt >= 14) ||
                ovf !== (i >= 16) || rempty !== 1'b0) begin
                failures++;
                $display("FAIL fill[%0d]: count=%0d full=%b afull=%b ovf=%b empty=%b required %0d %b %b %b 0",
                         i, count, wfull, afull, ovf, rempty, cnt, cnt == 16, cnt >= 14, i >= 16);
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_drain();
        int cnt;
        logic [7:0] exp;
        for (int k = 0; k < 18; k++) begin
            rinc = 1'b1;
            tick();
            cnt = (k < 16) ? 15 - k : 0;
            exp = (k < 16) ? 8'(k) : 8'd15;
            checks++;
            if (rdata !== exp || count !== 5'(cnt) || rempty !== (cnt == 0) ||
                unf !== (k >= 16) || aempty !== (cnt <= 2)) begin
                failures++;
                $display("FAIL drain[%0d]: rdata=%h count=%0d empty=%b unf=%b aempty=%b required %h %0d %b %b %b",
                         k, rdata, count, rempty, unf, aempty, exp, cnt, cnt == 0, k >= 16, cnt <= 2);
            end
        end
        rinc = 1'b0;
    endtask

    task automatic test_fwft();
        wdata1 = 8'hA5;
        winc1 = 1'b1;
        tick();
        checks++;
        if (rdata1 !== 8'hA5 || rempty1 !== 1'b0) begin
            failures++;
            $display("FAIL fwft_first: rdata=%h empty=%b required a5 0", rdata1, rempty1);
        end
        wdata1 = 8'h3C;
        tick();
        winc1 = 1'b0;
        checks++;
        if (rdata1 !== 8'hA5 || count1 !== 5'd2) begin
            failures++;
            $display("FAIL fwft_hold: rdata=%h count=%0d required a5 2", rdata1, count1);
        end
        rinc1 = 1'b1;
        tick();
        rinc1 = 1'b0;
        checks++;
        if (rdata1 !== 8'h3C || count1 !== 5'd1) begin
            failures++;
            $display("FAIL fwft_pop: rdata=%h count=%0d required 3c 1", rdata1, count1);
        end
        rinc1 = 1'b1;
        tick();
        rinc1 = 1'b0;
        checks++;
        if (rempty1 !== 1'b1 || count1 !== 5'd0) begin
            failures++;
            $display("FAIL fwft_empty: empty=%b count=%0d required 1 0", rempty1, count1);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        checks++;
        if (count !== 5'd0 || unf !== 1'b0 || ovf !== 1'b0 || rdata !== 8'd15) begin
            failures++;
            $display("FAIL flush_clear: count=%0d unf=%b ovf=%b rdata=%h required 0 0 0 0f", count, unf, ovf, rdata);
        end
        for (int i = 0; i < 5; i++) begin
            wdata = 8'(100 + i);
            winc = 1'b1;
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            wdata = 8'(105 + j);
            winc = 1'b1;
            rinc = 1'b1;
            tick();
            checks++;
            if (count !== 5'd5 || rdata !== 8'(100 + j)) begin
                failures++;
                $display("FAIL simul[%0d]: count=%0d rdata=%0d required 5 %0d", j, count, rdata, 100 + j);
            end
        end
        winc = 1'b0;
        for (int j = 0; j < 5; j++) begin
            rinc = 1'b1;
            tick();
            checks++;
            if (rdata !== 8'(110 + j) || count !== 5'(4 - j)) begin
                failures++;
                $display("FAIL simul_drain[%0d]: rdata=%0d count=%0d required %0d %0d", j, rdata, count, 110 + j, 4 - j);
            end
        end
        rinc = 1'b0;
        // Full: write is rejected even though the read is accepted.
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(200 + i);
            winc = 1'b1;
            tick();
        end
        wdata = 8'hEE;
        rinc = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        checks++;
        if (count !== 5'd15 || ovf !== 1'b1 || wfull !== 1'b0 || rdata !== 8'd200) begin
            failures++;
            $display("FAIL full_both: count=%0d ovf=%b full=%b rdata=%0d required 15 1 0 200", count, ovf, wfull, rdata);
        end
        // Empty: read is rejected even though the write is accepted.
        do_flush();
        wdata = 8'h77;
        winc = 1'b1;
        rinc = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        checks++;
        if (count !== 5'd1 || unf !== 1'b1 || rempty !== 1'b0 || rdata !== 8'd200) begin
            failures++;
            $display("FAIL empty_both: count=%0d unf=%b empty=%b rdata=%0d required 1 1 0 200", count, unf, rempty, rdata);
        end
    endtask

    task automatic test_flush_thr();
        do_flush();
        for (int i = 0; i < 17; i++) begin
            wdata = 8'(i + 1);
            winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rinc = 1'b1;
            tick();
        end
        rinc = 1'b0;
        checks++;
        if (count !== 5'd9 || ovf !== 1'b1 || rdata !== 8'd7) begin
            failures++;
            $display("FAIL pre_flush: count=%0d ovf=%b rdata=%0d required 9 1 7", count, ovf, rdata);
        end
        flush = 1'b1;
        winc = 1'b1;
        wdata = 8'h55;
        tick();
        flush = 1'b0;
        winc = 1'b0;
        checks++;
        if (count !== 5'd0 || rempty !== 1'b1 || ovf !== 1'b0 || rdata !== 8'd7) begin
            failures++;
            $display("FAIL flush_write: count=%0d empty=%b ovf=%b rdata=%0d required 0 1 0 7", count, rempty, ovf, rdata);
        end
        tick();
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL flush_discard: count=%0d required 0", count);
        end
        afull_thr = 5'd9;
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(40 + i);
            winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        checks++;
        if (afull !== 1'b0 || count !== 5'd4) begin
            failures++;
            $display("FAIL thr9: afull=%b count=%0d required 0 4", afull, count);
        end
        afull_thr = 5'd3;
        #1;
        checks++;
        if (afull !== 1'b1) begin
            failures++;
            $display("FAIL thr3: afull=%b required 1", afull);
        end
        afull_thr = 5'd17;
        aempty_thr = 5'd4;
        #1;
        checks++;
        if (afull !== 1'b0 || aempty !== 1'b1) begin
            failures++;
            $display("FAIL thr17: afull=%b aempty=%b required 0 1", afull, aempty);
        end
        afull_thr = 5'd0;
        aempty_thr = 5'd3;
        #1;
        checks++;
        if (afull !== 1'b1 || aempty !== 1'b0 || afull1 !== 1'b1) begin
            failures++;
            $display("FAIL thr0: afull=%b aempty=%b afull_fwft=%b required 1 0 1", afull, aempty, afull1);
        end
        afull_thr = 5'd14;
        aempty_thr = 5'd2;
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < 8; i++) begin
            wdata = 8'(60 + i);
            winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        checks++;
        if (count !== 5'd7 || rdata !== 8'd60) begin
            failures++;
            $display("FAIL pre_reset: count=%0d rdata=%0d required 7 60", count, rdata);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0 || rdata !== 8'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: count=%0d empty=%b full=%b rdata=%0d ovf=%b required 0 1 0 0 0",
                     count, rempty, wfull, rdata, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 43; c++) begin
            winc = (c < 40);
            wdata = 8'(c + 50);
            rinc = (c >= 3);
            tick();
            if (c >= 3) begin
                checks++;
                if (rdata !== 8'(c + 47)) begin
                    failures++;
                    $display("FAIL wrap[%0d]: rdata=%0d required %0d", c, rdata, c + 47);
                end
            end
        end
        winc = 1'b0;
        rinc = 1'b0;
        checks++;
        if (count !== 5'd0 || rempty !== 1'b1 || unf !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: count=%0d empty=%b unf=%b required 0 1 0", count, rempty, unf);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_back_to_back();
        test_flush_thr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
